// File: rtl/lcd_delay_scheduler.sv
// lcd_delay_scheduler: round-robin sharing of one 100us tick timer among NREQ delay requesters.
// Optional tick watchdog is compiled in with `define LCD_DLY_TIMEOUT_EN.
module lcd_delay_scheduler #(
    parameter int unsigned NREQ   = 3,
    parameter int unsigned DLY_W  = 8,
    parameter int unsigned TO_CYC = 12000
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DLY_W-1:0] delay_ticks,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  timer_en,
    output logic                  timer_dis,
    input  logic                  timer_tick,
    output logic                  timeout_err
);
    localparam int unsigned PTR_W = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TO_CYC < 1 || TO_CYC > 65535) begin : g_param_check
        $error("lcd_delay_scheduler: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DONE,
        ST_RELEASE
    } state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              busy_q, busy_d;
    logic              timer_en_q, timer_en_d;
    logic              timer_dis_q, timer_dis_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [DLY_W-1:0]  cnt_q, cnt_d;

    logic              win_found;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  rr_next;
    logic [DLY_W-1:0]  win_delay;
    logic              owner_req;
    logic              timeout_hit;
    int unsigned       scan_idx;

    // Scan rr_ptr, rr_ptr+1, .. wrapping at NREQ; first set request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            scan_idx = 32'(rr_ptr_q) + i;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!win_found && req[PTR_W'(scan_idx)]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(scan_idx);
            end
        end
    end

    always_comb begin
        win_delay = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                win_delay = delay_ticks[i*DLY_W +: DLY_W];
            end
        end
    end

    assign rr_next   = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);
    assign owner_req = |(req & grant_q);

`ifdef LCD_DLY_TIMEOUT_EN
    localparam logic [15:0] WD_LIM = 16'(TO_CYC - 1);

    logic [15:0] wd_q, wd_d;
    logic        timeout_err_q, timeout_err_d;

    assign timeout_hit = (wd_q == WD_LIM);

    // Watchdog restarts on entry to COUNT and on every tick.
    always_comb begin
        wd_d = '0;
        if (state_q == ST_COUNT && state_d == ST_COUNT && !timer_tick) begin
            wd_d = wd_q + 16'd1;
        end
        timeout_err_d = timeout_err_q;
        if (state_q == ST_COUNT && state_d == ST_DONE && !timer_tick) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_q          <= wd_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        done_d   = '0;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    cnt_d            = win_delay;
                    rr_ptr_d         = rr_next;
                    state_d          = (win_delay == '0) ? ST_DONE : ST_COUNT;
                end
            end
            ST_COUNT: begin
                // An owner dropping its request overrides a coincident tick.
                if (!owner_req) begin
                    state_d = ST_RELEASE;
                end else if (timer_tick) begin
                    cnt_d = cnt_q - DLY_W'(1);
                    if (cnt_q == DLY_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = grant_q;
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d      = (state_d != ST_IDLE);
        timer_en_d  = (state_d == ST_COUNT);
        timer_dis_d = (state_q == ST_RELEASE);
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            timer_en_q  <= 1'b0;
            timer_dis_q <= 1'b1;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            timer_en_q  <= timer_en_d;
            timer_dis_q <= timer_dis_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign timer_en  = timer_en_q;
    assign timer_dis = timer_dis_q;

endmodule

// File: tb/tb_lcd_delay_scheduler.sv
// Scoreboard bench for lcd_delay_scheduler: grant/done events are queued with their expected cycle.
module tb_lcd_delay_scheduler;
    localparam int NREQ   = 3;
    localparam int DLY_W  = 8;
    localparam int TO_CYC = 50;

    logic                  clock = 1'b0;
    logic                  rst   = 1'b0;
    logic [NREQ-1:0]       req   = '0;
    logic [NREQ*DLY_W-1:0] delay_ticks = '0;
    logic                  timer_tick  = 1'b0;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic                  timer_en;
    logic                  timer_dis;
    logic                  timeout_err;

    typedef struct {
        bit          is_done;
        logic [2:0]  val;
        int          cyc;
    } ev_t;

    ev_t        exp_q[$];
    int         n_vec = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    logic [2:0] prev_grant = '0;

    lcd_delay_scheduler #(
        .NREQ   (NREQ),
        .DLY_W  (DLY_W),
        .TO_CYC (TO_CYC)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .req         (req),
        .delay_ticks (delay_ticks),
        .grant       (grant),
        .done        (done),
        .busy        (busy),
        .timer_en    (timer_en),
        .timer_dis   (timer_dis),
        .timer_tick  (timer_tick),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input bit is_done, input logic [2:0] val, input int at);
        ev_t e;
        e.is_done = is_done;
        e.val     = val;
        e.cyc     = at;
        exp_q.push_back(e);
    endtask

    task automatic mon_check(input bit is_done, input logic [2:0] val);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_%s: got %b at cyc %0d, required no event",
                     is_done ? "done" : "grant", val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.is_done != is_done || e.val !== val || e.cyc != cyc) begin
                n_bad++;
                $display("FAIL event: got %s=%b at cyc %0d, required %s=%b at cyc %0d",
                         is_done ? "done" : "grant", val, cyc,
                         e.is_done ? "done" : "grant", e.val, e.cyc);
            end
        end
    endtask

    always @(negedge clock) begin
        if (rst) begin
            if (grant != prev_grant && grant != 3'b000) mon_check(1'b0, grant);
            if (done != 3'b000) mon_check(1'b1, done);
        end
        prev_grant = grant;
    end

    task automatic set_delay(input int idx, input logic [7:0] d);
        delay_ticks[idx*DLY_W +: DLY_W] = d;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        req        = '0;
        timer_tick = 1'b0;
        step(2);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_timer_en", 32'(timer_en), 0);
        chk("rst_timer_dis", 32'(timer_dis), 1);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        rst = 1'b1;
    endtask

    // Owner is granted on the next edge, receives d ticks spaced by gap idle cycles,
    // then drops its request the cycle done is seen.
    task automatic serve(input logic [2:0] owner, input int d, input int gap);
        logic [NREQ*DLY_W-1:0] saved;
        expect_ev(1'b0, owner, cyc + 1);
        step(1);
        chk("timer_en_at_grant", 32'(timer_en), 32'(d != 0));
        chk("busy_at_grant", 32'(busy), 1);
        saved       = delay_ticks;
        delay_ticks = ~delay_ticks;
        for (int k = 0; k < d; k++) begin
            step(gap);
            timer_tick = 1'b1;
            step(1);
            timer_tick = 1'b0;
        end
        expect_ev(1'b1, owner, cyc + 1);
        step(1);
        chk("timer_dis_with_done", 32'(timer_dis), 0);
        chk("timer_en_with_done", 32'(timer_en), 0);
        req = req & ~owner;
        step(1);
        chk("timer_dis_pulse", 32'(timer_dis), 1);
        chk("grant_cleared", 32'(grant), 0);
        chk("busy_idle", 32'(busy), 0);
        delay_ticks = saved;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish by 200000");
        $fatal(1, "bench timeout");
    end

    initial begin
        do_reset();

        // single requester, delay 3, tick every 20 clocks
        set_delay(0, 8'd3);
        req = 3'b001;
        serve(3'b001, 3, 19);
        step(1);
        chk("dis_one_cycle", 32'(timer_dis), 0);

        // three simultaneous requesters from rr_ptr 0
        do_reset();
        set_delay(0, 8'd1);
        set_delay(1, 8'd1);
        set_delay(2, 8'd1);
        req = 3'b111;
        serve(3'b001, 1, 3);
        serve(3'b010, 1, 3);
        serve(3'b100, 1, 3);
        // rr_ptr back to 0: req0 first, then req1 beats a re-raised req0
        req = 3'b011;
        serve(3'b001, 1, 0);
        req = req | 3'b001;
        serve(3'b010, 1, 0);
        serve(3'b001, 1, 0);

        // zero delay: done the cycle after grant, timer never enabled
        set_delay(2, 8'd0);
        req = 3'b100;
        serve(3'b100, 0, 0);

        // abort after 2 of 5 ticks, with a tick coinciding with the drop
        set_delay(1, 8'd5);
        req = 3'b010;
        expect_ev(1'b0, 3'b010, cyc + 1);
        step(1);
        for (int k = 0; k < 2; k++) begin
            step(4);
            timer_tick = 1'b1;
            step(1);
            timer_tick = 1'b0;
        end
        step(2);
        timer_tick = 1'b1;
        req        = 3'b000;
        step(1);
        timer_tick = 1'b0;
        chk("abort_dis_not_yet", 32'(timer_dis), 0);
        chk("abort_busy_release", 32'(busy), 1);
        step(1);
        chk("abort_timer_dis", 32'(timer_dis), 1);
        chk("abort_grant", 32'(grant), 0);
        chk("abort_busy_low", 32'(busy), 0);
        step(8);
        chk("abort_done_quiet", 32'(done), 0);

        // async reset in COUNT after 2 of 4 ticks
        set_delay(0, 8'd4);
        req = 3'b001;
        expect_ev(1'b0, 3'b001, cyc + 1);
        step(1);
        for (int k = 0; k < 2; k++) begin
            step(3);
            timer_tick = 1'b1;
            step(1);
            timer_tick = 1'b0;
        end
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_grant", 32'(grant), 0);
        chk("midrst_timer_dis", 32'(timer_dis), 1);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_timer_en", 32'(timer_en), 0);
        step(1);
        req = 3'b000;
        rst = 1'b1;
        set_delay(0, 8'd2);
        req = 3'b001;
        serve(3'b001, 2, 4);

        // no ticks at all
        set_delay(0, 8'd2);
        req = 3'b001;
        expect_ev(1'b0, 3'b001, cyc + 1);
        step(1);
`ifdef LCD_DLY_TIMEOUT_EN
        step(49);
        chk("timeout_before_limit", 32'(timeout_err), 0);
        step(1);
        chk("timeout_flag", 32'(timeout_err), 1);
        expect_ev(1'b1, 3'b001, cyc + 1);
        step(1);
        req = 3'b000;
        step(1);
        chk("timeout_release", 32'(timer_dis), 1);
        step(5);
        chk("timeout_sticky", 32'(timeout_err), 1);
`else
        step(200);
        chk("notick_busy", 32'(busy), 1);
        chk("notick_timer_en", 32'(timer_en), 1);
        chk("notick_timeout_err", 32'(timeout_err), 0);
        req = 3'b000;
        step(2);
        chk("notick_release", 32'(timer_dis), 1);
`endif

        step(3);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
